// File: rtl/fib_mem_writer.sv
// rtl/fib_mem_writer.sv - Fibonacci term generator that fills a RAM region and verifies it by readback
module fib_mem_writer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        count,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              mismatch,
  output logic [DATA_W-1:0] last_term
);

  typedef enum logic [1:0] {IDLE, WRITE, CHECK, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] a, b;
  logic              a_ovf, b_ovf;
  logic [7:0]        idx, cnt_r;
  logic [ADDR_W-1:0] base_r;

  logic [DATA_W:0]   sum;
  logic              last;
  logic [ADDR_W-1:0] next_addr;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign last      = (idx == cnt_r - 8'd1);
  assign next_addr = base_r + ADDR_W'(idx) + ADDR_W'(1);

  // Memory outputs are registered one step ahead so they already hold the
  // address/term of the cycle being entered; a is the term owned by idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      mismatch  <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_term <= '0;
      a         <= '0;
      b         <= '0;
      a_ovf     <= 1'b0;
      b_ovf     <= 1'b0;
      idx       <= '0;
      base_r    <= '0;
      cnt_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          mem_wr_en <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (start) begin
            base_r   <= base_addr;
            cnt_r    <= count;
            overflow <= 1'b0;
            mismatch <= 1'b0;
            a        <= '0;
            b        <= DATA_W'(1);
            a_ovf    <= 1'b0;
            b_ovf    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b1;
            if (count == 8'd0) begin
              state <= DONE;
            end else begin
              state     <= WRITE;
              mem_wr_en <= 1'b1;
              mem_addr  <= base_addr;
              mem_wdata <= '0;
            end
          end
        end

        WRITE: begin
          a         <= b;
          a_ovf     <= b_ovf;
          b         <= sum[DATA_W-1:0];
          b_ovf     <= sum[DATA_W] | a_ovf | b_ovf;
          last_term <= a;
          if (a_ovf) overflow <= 1'b1;
          if (last) begin
            state     <= CHECK;
            idx       <= '0;
            a         <= '0;
            b         <= DATA_W'(1);
            a_ovf     <= 1'b0;
            b_ovf     <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= base_r;
            mem_wdata <= '0;
          end else begin
            idx       <= idx + 8'd1;
            mem_addr  <= next_addr;
            mem_wdata <= b;
          end
        end

        CHECK: begin
          if (mem_rdata != a) mismatch <= 1'b1;
          a     <= b;
          a_ovf <= b_ovf;
          b     <= sum[DATA_W-1:0];
          b_ovf <= sum[DATA_W] | a_ovf | b_ovf;
          if (last) begin
            state    <= DONE;
            idx      <= '0;
            mem_addr <= '0;
          end else begin
            idx      <= idx + 8'd1;
            mem_addr <= next_addr;
          end
        end

        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_mem_writer.sv
// tb/tb_fib_mem_writer.sv - randomized self-checking bench for fib_mem_writer with a RAM model
module tb_fib_mem_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic [7:0] count = 8'd0;
  logic       mem_wr_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy, done, overflow, mismatch;
  logic [7:0] last_term;

  fib_mem_writer #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .overflow(overflow), .mismatch(mismatch), .last_term(last_term)
  );

  always #5 clk = ~clk;

  // RAM model: falling-edge write, combinational read with optional read corruption
  logic [7:0] ram [256];
  int         wr_count = 0;
  logic       corrupt_en = 1'b0;
  logic [7:0] corrupt_addr = 8'd0;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      ram[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  assign mem_rdata = (corrupt_en && !mem_wr_en && busy && mem_addr == corrupt_addr)
                     ? ~ram[mem_addr] : ram[mem_addr];

  // Reference sequence: terms mod 256 and saturated exact values
  logic [7:0] fm [256];
  longint     fx [256];
  logic [7:0] last_exp = 8'd0;
  int         passed = 0;
  int         total = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic run(input logic [7:0] b, input int n, input int cor, input bit extra);
    int         w0, lat, pulses;
    logic [7:0] ad;
    bit         ovf_exp;
    corrupt_en   = (cor >= 0);
    corrupt_addr = b + 8'(cor);
    w0 = wr_count;
    @(negedge clk);
    base_addr = b;
    count     = 8'(n);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 8'($urandom);
    count     = 8'($urandom);
    chk("busy_after_start", busy, 1);
    lat = -1;
    pulses = 0;
    for (int k = 1; k <= 2 * n + 6; k++) begin
      @(posedge clk);
      #1;
      if (extra && k == 3) start = 1'b1;
      if (extra && k == 4) start = 1'b0;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          chk("busy_at_done", busy, 0);
        end
      end
    end
    ovf_exp = 1'b0;
    for (int k = 0; k < n; k++) if (fx[k] > 255) ovf_exp = 1'b1;
    if (n > 0) last_exp = fm[n-1];
    chk("done_latency", lat, 2 * n + 1);
    chk("done_pulses", pulses, 1);
    chk("write_count", wr_count - w0, n);
    chk("overflow", overflow, int'(ovf_exp));
    chk("mismatch", mismatch, int'(cor >= 0 && cor < n));
    chk("last_term", last_term, last_exp);
    for (int k = 0; k < n; k++) begin
      ad = b + 8'(k);
      chk($sformatf("ram[%02h]", ad), ram[ad], fm[k]);
    end
    corrupt_en = 1'b0;
  endtask

  task automatic reset_abort(input logic [7:0] b);
    int         w0;
    logic [7:0] pre;
    logic [7:0] ad;
    pre = ram[b + 8'd3];
    w0  = wr_count;
    @(negedge clk);
    base_addr = b;
    count     = 8'd10;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #6 rst_n = 1'b0;
    #1;
    chk("abort_wr_en", mem_wr_en, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    chk("abort_busy", busy, 0);
    chk("abort_last_term", last_term, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_write_count", wr_count - w0, 3);
    for (int k = 0; k < 3; k++) begin
      ad = b + 8'(k);
      chk($sformatf("abort_ram[%02h]", ad), ram[ad], fm[k]);
    end
    chk("abort_ram_untouched", ram[b + 8'd3], pre);
    last_exp = 8'd0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    int n, cor;
    fm[0] = 8'd0;
    fm[1] = 8'd1;
    fx[0] = 0;
    fx[1] = 1;
    for (int k = 2; k < 256; k++) begin
      fm[k] = fm[k-1] + fm[k-2];
      fx[k] = fx[k-1] + fx[k-2];
      if (fx[k] > 1000) fx[k] = 1000;
    end

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_last_term", last_term, 0);
    @(negedge clk) rst_n = 1'b1;

    run(8'h10, 5, -1, 1'b0);
    run(8'hFE, 4, -1, 1'b0);
    run(8'h40, 14, -1, 1'b0);
    run(8'h40, 15, -1, 1'b0);
    run(8'h60, 6, 2, 1'b0);
    run(8'h70, 0, -1, 1'b0);
    run(8'h80, 8, -1, 1'b1);
    run(8'h00, 255, -1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      n   = int'($urandom_range(1, 40));
      cor = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run(8'($urandom), n, cor, 1'b0);
    end
    reset_abort(8'h90);
    run(8'h20, 3, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
